// File: rtl/ltc_reader_pkg.sv
// Shared types and constants for the LTC timestamp FIFO reader.
// Optional delta/monotonicity outputs are enabled with LTC_READER_DELTA_EN.
package ltc_reader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO_WAIT = 3'd1,
        HI_REQ  = 3'd2,
        HI_WAIT = 3'd3,
        OUT     = 3'd4
    } state_t;

    typedef logic [63:0] ts_t;

    localparam logic [31:0] DELTA_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ltc_word_assembler.sv
// Joins the two popped FIFO words into a 64-bit timestamp; with LTC_READER_DELTA_EN
// it also derives the saturated delta to the previous accepted timestamp.
module ltc_word_assembler
    import ltc_reader_pkg::*;
(
    input  logic [31:0] first_word,
    input  logic [31:0] second_word,
    input  logic        low_first,
`ifdef LTC_READER_DELTA_EN
    input  ts_t         prev_ts,
    input  logic        have_prev,
    output logic [31:0] delta,
    output logic        not_greater,
`endif
    output ts_t         ts
);

    assign ts = low_first ? {second_word, first_word} : {first_word, second_word};

`ifdef LTC_READER_DELTA_EN
    ts_t diff;

    // A backwards step wraps to a huge 64-bit value and therefore saturates too.
    assign diff        = ts - prev_ts;
    assign delta       = !have_prev ? 32'd0 : ((diff[63:32] != 32'd0) ? DELTA_SAT : diff[31:0]);
    assign not_greater = have_prev && (ts <= prev_ts);
`endif

endmodule

// File: rtl/ltc_timestamp_reader.sv
// Drains the LTC timestamp FIFO two words at a time and streams 64-bit timestamps
// over AXI-Stream with tlast every BURST_LEN beats. Optional macro: LTC_READER_DELTA_EN.
module ltc_timestamp_reader
    import ltc_reader_pkg::*;
#(
    parameter int unsigned BURST_LEN      = 16,
    parameter bit          LOW_WORD_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        flush,
    input  logic        FIFO_notEmpty,
    input  logic [31:0] FIFO_dout,
    output logic        FIFO_rden,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef LTC_READER_DELTA_EN
    output logic [31:0] m_axis_tuser,
    output logic        nonmono_err,
`endif
    output logic [31:0] ts_count,
    output logic        busy
);

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] lo_word;
    logic        tlast_r;
    logic [15:0] frame_cnt;
    logic        flush_pend;
    logic        handshake;
    logic        drop;
    ts_t         asm_ts;

    // Valid/ready: a beat transfers on any cycle where tvalid and tready are both
    // high; tvalid never drops and tdata/tlast never change until that happens.
    assign handshake = (state == OUT) && m_axis_tready;
    // A flush seen in OUT is remembered until the held beat is accepted.
    assign drop      = flush || flush_pend;

`ifdef LTC_READER_DELTA_EN
    ts_t         prev_ts;
    logic        have_prev;
    logic [31:0] asm_delta;
    logic        asm_not_greater;
    logic        not_greater_r;

    ltc_word_assembler u_asm (
        .first_word  (lo_word),
        .second_word (FIFO_dout),
        .low_first   (LOW_WORD_FIRST),
        .prev_ts     (prev_ts),
        .have_prev   (have_prev),
        .delta       (asm_delta),
        .not_greater (asm_not_greater),
        .ts          (asm_ts)
    );
`else
    ltc_word_assembler u_asm (
        .first_word  (lo_word),
        .second_word (FIFO_dout),
        .low_first   (LOW_WORD_FIRST),
        .ts          (asm_ts)
    );
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable && FIFO_notEmpty) state_next = LO_WAIT;
            LO_WAIT: state_next = FIFO_notEmpty ? HI_WAIT : HI_REQ;
            HI_REQ:  if (FIFO_notEmpty) state_next = HI_WAIT;
            HI_WAIT: state_next = OUT;
            OUT:     if (handshake) state_next = (!drop && enable && FIFO_notEmpty) ? LO_WAIT : IDLE;
            default: state_next = IDLE;
        endcase
        // A pop issued alongside the flush still lands next cycle; IDLE ignores it.
        if (flush && state != OUT) state_next = IDLE;
    end

    always_comb begin
        FIFO_rden = 1'b0;
        unique case (state)
            IDLE:            FIFO_rden = enable && FIFO_notEmpty;
            LO_WAIT, HI_REQ: FIFO_rden = FIFO_notEmpty;
            OUT:             FIFO_rden = handshake && !drop && enable && FIFO_notEmpty;
            default:         FIFO_rden = 1'b0;
        endcase
        m_axis_tvalid = (state == OUT);
        m_axis_tlast  = (state == OUT) && tlast_r;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lo_word      <= '0;
            m_axis_tdata <= '0;
            tlast_r      <= 1'b0;
            frame_cnt    <= '0;
            flush_pend   <= 1'b0;
            ts_count     <= '0;
        end else begin
            if (state == LO_WAIT) lo_word <= FIFO_dout;
            // tlast is frozen with the data so a flush during stall cannot alter it.
            if (state == HI_WAIT && !flush) begin
                m_axis_tdata <= asm_ts;
                tlast_r      <= (frame_cnt == LAST_IDX);
            end
            if (handshake) ts_count <= ts_count + 32'd1;
            if (handshake) frame_cnt <= (drop || frame_cnt == LAST_IDX) ? 16'd0 : frame_cnt + 16'd1;
            else if (flush) frame_cnt <= 16'd0;
            flush_pend <= (state == OUT) && !handshake && drop;
        end
    end

`ifdef LTC_READER_DELTA_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            prev_ts       <= '0;
            have_prev     <= 1'b0;
            m_axis_tuser  <= '0;
            not_greater_r <= 1'b0;
            nonmono_err   <= 1'b0;
        end else begin
            if (state == HI_WAIT && !flush) begin
                m_axis_tuser  <= asm_delta;
                not_greater_r <= asm_not_greater;
            end
            if (handshake && !drop) begin
                prev_ts   <= m_axis_tdata;
                have_prev <= 1'b1;
            end else if (handshake || flush) begin
                have_prev <= 1'b0;
            end
            if (flush) nonmono_err <= 1'b0;
            else if (handshake && !flush_pend && not_greater_r) nonmono_err <= 1'b1;
        end
    end
`endif

endmodule
